// File: rtl/led_activity_scheduler_if.sv
// Port-side signal bundle for led_activity_scheduler.
// The slave modport is the scheduler itself; the master modport is whoever
// drives link status, traffic events and the lamp-test request.
//   has_link_i          per-port link status
//   on_frame_sent_i     per-port single-cycle TX event pulses
//   on_frame_received_i per-port single-cycle RX event pulses
//   lamp_test_i         lamp-test request (rising-edge sensitive)
//   led_o               led_o[2k] = port k TX LED, led_o[2k+1] = port k RX LED, 1 = lit
//   blink_o             shared blink timebase
//   busy_o              high while the lamp-test sequence runs
interface led_activity_scheduler_if #(
    parameter int unsigned NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]   has_link_i;
    logic [NUM_PORTS-1:0]   on_frame_sent_i;
    logic [NUM_PORTS-1:0]   on_frame_received_i;
    logic                   lamp_test_i;
    logic [2*NUM_PORTS-1:0] led_o;
    logic                   blink_o;
    logic                   busy_o;

    modport master (
        output has_link_i,
        output on_frame_sent_i,
        output on_frame_received_i,
        output lamp_test_i,
        input  led_o,
        input  blink_o,
        input  busy_o
    );

    modport slave (
        input  has_link_i,
        input  on_frame_sent_i,
        input  on_frame_received_i,
        input  lamp_test_i,
        output led_o,
        output blink_o,
        output busy_o
    );
endinterface

// File: rtl/led_activity_scheduler.sv
// Per-port Ethernet TX/RX activity LED scheduler with lamp test.
// After reset (or a lamp-test request in RUN) the LEDs are walked one at a time,
// then all lit, then normal operation starts: a LED is lit while its port has
// link and is blanked for one blink-high window when traffic was seen.
//   clk_i  single clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    led_activity_scheduler_if.slave (link/events/lamp test in, LEDs/blink/busy out)
module led_activity_scheduler #(
    parameter int unsigned NUM_PORTS         = 4,
    parameter int unsigned BLINK_HALF_CYCLES = 6250000,
    parameter int unsigned TEST_STEP_CYCLES  = 12500000
) (
    input logic                      clk_i,
    input logic                      rst_i,
    led_activity_scheduler_if.slave  bus
);
    localparam int unsigned NumLeds = 2 * NUM_PORTS;
    localparam int unsigned StepW   = (NumLeds > 1) ? $clog2(NumLeds) : 1;
    localparam int unsigned TestW   = (TEST_STEP_CYCLES > 1) ? $clog2(TEST_STEP_CYCLES) : 1;
    localparam int unsigned BlinkW  = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

    localparam logic [TestW-1:0]  TestMax  = TestW'(TEST_STEP_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_HALF_CYCLES - 1);
    localparam logic [StepW-1:0]  StepLast = StepW'(NumLeds - 1);

    typedef enum logic [1:0] {StWalk, StAllOn, StRun} state_e;

    state_e               state_q, state_d;
    logic [StepW-1:0]     step_q, step_d;
    logic [TestW-1:0]     test_cnt_q, test_cnt_d;
    logic [BlinkW-1:0]    blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;
    logic                 lamp_prev_q;
    logic [NUM_PORTS-1:0] act_tx_q, act_tx_d, act_rx_q, act_rx_d;
    logic [NUM_PORTS-1:0] off_tx_q, off_tx_d, off_rx_q, off_rx_d;
    logic [NumLeds-1:0]   led;
    logic                 busy;

    logic step_end, lamp_rise, blink_wrap;

    assign step_end   = (test_cnt_q == TestMax);
    assign lamp_rise  = bus.lamp_test_i & ~lamp_prev_q;
    assign blink_wrap = (blink_cnt_q == BlinkMax);

    always_ff @(posedge clk_i) begin : p_state_reg
        if (rst_i) begin
            state_q <= StWalk;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        unique case (state_q)
            StWalk:  if (step_end && (step_q == StepLast)) state_d = StAllOn;
            StAllOn: if (step_end) state_d = StRun;
            StRun:   if (lamp_rise) state_d = StWalk;
            default: state_d = StWalk;
        endcase
    end

    always_comb begin : p_outputs
        led  = NumLeds'(1);
        busy = 1'b1;
        if (!rst_i) begin
            unique case (state_q)
                StWalk:  led = NumLeds'(1) << step_q;
                StAllOn: led = '1;
                StRun: begin
                    busy = 1'b0;
                    for (int k = 0; k < int'(NUM_PORTS); k++) begin
                        led[2*k]   = bus.has_link_i[k] & ~off_tx_q[k];
                        led[2*k+1] = bus.has_link_i[k] & ~off_rx_q[k];
                    end
                end
                default: led = NumLeds'(1);
            endcase
        end
    end

    assign bus.led_o   = led;
    assign bus.busy_o  = busy;
    assign bus.blink_o = blink_q;

    always_comb begin : p_datapath
        step_d      = step_q;
        test_cnt_d  = test_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        act_tx_d    = act_tx_q;
        act_rx_d    = act_rx_q;
        off_tx_d    = off_tx_q;
        off_rx_d    = off_rx_q;

        // Lamp-test step timing; idle at zero while running normally.
        if (state_q == StRun) begin
            step_d     = '0;
            test_cnt_d = '0;
        end else if (step_end) begin
            test_cnt_d = '0;
            step_d     = ((state_q == StWalk) && (step_q != StepLast)) ? step_q + StepW'(1) : '0;
        end else begin
            test_cnt_d = test_cnt_q + TestW'(1);
        end

        // Activity/blink logic only lives in RUN; leaving RUN clears everything.
        if ((state_q != StRun) || lamp_rise) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
            act_tx_d    = '0;
            act_rx_d    = '0;
            off_tx_d    = '0;
            off_rx_d    = '0;
        end else if (blink_wrap) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
            if (!blink_q) begin
                // Report what was gathered so far; this cycle's events start the next window.
                off_tx_d = act_tx_q;
                off_rx_d = act_rx_q;
                act_tx_d = bus.on_frame_sent_i;
                act_rx_d = bus.on_frame_received_i;
            end else begin
                off_tx_d = '0;
                off_rx_d = '0;
                act_tx_d = act_tx_q | bus.on_frame_sent_i;
                act_rx_d = act_rx_q | bus.on_frame_received_i;
            end
        end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
            act_tx_d    = act_tx_q | bus.on_frame_sent_i;
            act_rx_d    = act_rx_q | bus.on_frame_received_i;
        end
    end

    always_ff @(posedge clk_i) begin : p_datapath_reg
        if (rst_i) begin
            step_q      <= '0;
            test_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            lamp_prev_q <= 1'b0;
            act_tx_q    <= '0;
            act_rx_q    <= '0;
            off_tx_q    <= '0;
            off_rx_q    <= '0;
        end else begin
            step_q      <= step_d;
            test_cnt_q  <= test_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            lamp_prev_q <= bus.lamp_test_i;
            act_tx_q    <= act_tx_d;
            act_rx_q    <= act_rx_d;
            off_tx_q    <= off_tx_d;
            off_rx_q    <= off_rx_d;
        end
    end
endmodule
